// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and word width shared by mdu_seq and the ALU decode.
package mdu_pkg;
    localparam int WORD_W = 32;

    localparam logic [4:0] OP_MUL   = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_REM   = 5'd5;
    localparam logic [4:0] OP_REMU  = 5'd6;
    localparam logic [4:0] OP_MULW  = 5'd24;
    localparam logic [4:0] OP_DIVW  = 5'd25;
    localparam logic [4:0] OP_DIVUW = 5'd26;
    localparam logic [4:0] OP_REMW  = 5'd27;
    localparam logic [4:0] OP_REMUW = 5'd28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one restoring-division step on unsigned magnitudes.
// Latency: combinational.
// Backpressure: none; stepped by the mdu_seq FSM.
module mdu_div_step #(
    parameter int N = 64
) (
    input  logic [N-1:0] rem,
    input  logic [N-1:0] divisor,
    input  logic         din,
    output logic [N-1:0] rem_nxt,
    output logic         qbit
);
    logic [N:0] shifted;
    logic [N:0] diff;

    // rem < divisor always holds, so a clear borrow bit means shifted >= divisor
    assign shifted = {rem, din};
    assign diff    = shifted - {1'b0, divisor};
    assign qbit    = ~diff[N];
    assign rem_nxt = qbit ? diff[N-1:0] : shifted[N-1:0];
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply (shift-add) / divide (restoring) unit; MDU_FAST_MUL_EN swaps in a single-cycle multiply.
// Latency: K+1 cycles (K = N, or 32 for word ops); 1 cycle for div-by-zero, overflow, unsupported ops.
// Backpressure: one op in flight; in_ready low until the result handshake, res held while out_valid && !out_ready.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res
);
    localparam int CW = $clog2(N + 1);

    function automatic logic [N-1:0] sext32(input logic [WORD_W-1:0] v);
        return {{(N-WORD_W){v[WORD_W-1]}}, v};
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt;
    logic [N-1:0]  acc_q, x_q, y_q;
    logic          word_q, rem_q, negq_q, negr_q;

    logic is_mul, is_div, is_word, is_signed, is_rem;
    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        is_rem    = 1'b0;
        case (op)
            OP_MUL:   is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_REM:   begin is_div = 1'b1; is_signed = 1'b1; is_rem = 1'b1; end
            OP_REMU:  begin is_div = 1'b1; is_rem = 1'b1; end
            OP_MULW:  begin is_mul = 1'b1; is_word = 1'b1; end
            OP_DIVW:  begin is_div = 1'b1; is_word = 1'b1; is_signed = 1'b1; end
            OP_DIVUW: begin is_div = 1'b1; is_word = 1'b1; end
            OP_REMW:  begin is_div = 1'b1; is_word = 1'b1; is_signed = 1'b1; is_rem = 1'b1; end
            OP_REMUW: begin is_div = 1'b1; is_word = 1'b1; is_rem = 1'b1; end
            default:  ;
        endcase
    end

    logic [N-1:0] a_sx, b_sx, a_zx, b_zx, a_mag, b_mag, spec_res, fast_res;
    logic         sa, sb, dz, ovf, special, fast_mul;

    assign a_sx  = is_word ? sext32(a[WORD_W-1:0]) : a;
    assign b_sx  = is_word ? sext32(b[WORD_W-1:0]) : b;
    assign a_zx  = is_word ? {{(N-WORD_W){1'b0}}, a[WORD_W-1:0]} : a;
    assign b_zx  = is_word ? {{(N-WORD_W){1'b0}}, b[WORD_W-1:0]} : b;
    assign sa    = is_signed & a_sx[N-1];
    assign sb    = is_signed & b_sx[N-1];
    assign a_mag = sa ? -a_sx : a_zx;
    assign b_mag = sb ? -b_sx : b_zx;

    assign dz  = (b_sx == '0);
    assign ovf = is_signed & (is_word
               ? (a[WORD_W-1:0] == {1'b1, {(WORD_W-1){1'b0}}}) && (&b[WORD_W-1:0])
               : (a == {1'b1, {(N-1){1'b0}}}) && (&b));
    assign special = !(is_mul || is_div) || (is_div && (dz || ovf));

    always_comb begin
        spec_res = '0;
        if (is_div && dz)
            spec_res = is_rem ? a_sx : '1;
        else if (is_div)
            spec_res = is_rem ? '0 : a_sx;
    end

`ifdef MDU_FAST_MUL_EN
    logic [N-1:0] prod;
    assign prod     = a * b;
    assign fast_res = is_word ? sext32(prod[WORD_W-1:0]) : prod;
    assign fast_mul = 1'b1;
`else
    assign fast_res = '0;
    assign fast_mul = 1'b0;
`endif

    logic [N-1:0]      div_rem, q_fin, raw, mul_acc, mul_res, div_res;
    logic [WORD_W-1:0] raw_w;
    logic              div_q, neg, last;

    mdu_div_step #(.N(N)) u_step (
        .rem     (acc_q),
        .divisor (y_q),
        .din     (x_q[N-1]),
        .rem_nxt (div_rem),
        .qbit    (div_q)
    );

    // the dividend register doubles as the quotient register, filling from the LSB
    assign q_fin   = {x_q[N-2:0], div_q};
    assign raw     = rem_q ? div_rem : q_fin;
    assign neg     = rem_q ? negr_q : negq_q;
    assign raw_w   = neg ? -raw[WORD_W-1:0] : raw[WORD_W-1:0];
    assign div_res = word_q ? sext32(raw_w) : (neg ? -raw : raw);
    assign mul_acc = acc_q + (x_q[0] ? y_q : '0);
    assign mul_res = word_q ? sext32(mul_acc[WORD_W-1:0]) : mul_acc;
    assign last    = word_q ? (cnt == CW'(WORD_W - 1)) : (cnt == CW'(N - 1));

    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                if (special || (is_mul && fast_mul)) state_d = ST_DONE;
                else if (is_mul)                     state_d = ST_MUL;
                else                                 state_d = ST_DIV;
            end
            ST_MUL, ST_DIV: if (last) state_d = ST_DONE;
            ST_DONE:        if (out_ready) state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            res    <= '0;
            acc_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            word_q <= 1'b0;
            rem_q  <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    word_q <= is_word;
                    rem_q  <= is_rem;
                    negq_q <= sa ^ sb;
                    negr_q <= sa;
                    acc_q  <= '0;
                    cnt    <= '0;
                    if (is_div) begin
                        y_q <= b_mag;
                        x_q <= is_word ? {a_mag[WORD_W-1:0], {(N-WORD_W){1'b0}}} : a_mag;
                    end else begin
                        y_q <= a;
                        x_q <= b;
                    end
                    if (special)                 res <= spec_res;
                    else if (is_mul && fast_mul) res <= fast_res;
                end
                ST_MUL: begin
                    acc_q <= mul_acc;
                    y_q   <= y_q << 1;
                    x_q   <= x_q >> 1;
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last) res <= mul_res;
                end
                ST_DIV: begin
                    acc_q <= div_rem;
                    x_q   <= q_fin;
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last) res <= div_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed vectors for mdu_seq with hand-computed results and latencies.
module tb_mdu_seq;
    localparam int N = 64;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MULW_LAT = 1;
`else
    localparam int MUL_LAT  = 65;
    localparam int MULW_LAT = 33;
`endif

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [4:0]   op;
    logic [N-1:0] a, b, res;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    mdu_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat = number of edges from accept to the edge that first sees out_valid
    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] o, input logic [N-1:0] va,
                          input logic [N-1:0] vb, input logic [N-1:0] exp_res, input int exp_lat);
        int lat;
        out_ready = 1'b0;
        check({tag, ".in_ready"}, N'(in_ready), N'(1));
        op = o; a = va; b = vb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; op = 5'd0; a = '1; b = '1;
        wait_valid(lat);
        check({tag, ".lat"}, N'(lat), N'(exp_lat));
        check({tag, ".res"}, res, exp_res);
        out_ready = 1'b1;
        tick();
        check({tag, ".done"}, N'({out_valid, in_ready}), N'(2'b01));
    endtask

    initial begin
        int lat;
        logic ok;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 5'd0; a = '0; b = '0;
        tick();
        tick();
        check("rst.in_ready", N'(in_ready), N'(0));
        check("rst.out_valid", N'(out_valid), N'(0));
        check("rst.res", res, '0);
        rst_n = 1'b1;
        tick();
        check("rel.in_ready", N'(in_ready), N'(1));

        run_op("mul",      5'd2,  64'd3, '1, 64'hFFFF_FFFF_FFFF_FFFD, MUL_LAT);
        run_op("div",      5'd3,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem",      5'd5,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65);
        run_op("remu",     5'd6,  64'd7, 64'd2, 64'd1, 65);
        run_op("rem_neg",  5'd5,  64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65);
        run_op("divu0",    5'd4,  64'd5, 64'd0, '1, 1);
        run_op("remu0",    5'd6,  64'd5, 64'd0, 64'd5, 1);
        run_op("div_ovf",  5'd3,  64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run_op("divw_ovf", 5'd25, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("divw_z",   5'd25, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, '1, 1);
        run_op("mulw",     5'd24, 64'h1_0000_0002, 64'h7FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, MULW_LAT);
        run_op("divuw",    5'd26, 64'hABCD_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
        run_op("divw",     5'd25, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 33);
        run_op("remw",     5'd27, 64'h1234_5678_FFFF_FFF9, 64'h5555_0000_0000_0002, '1, 33);
        run_op("bad_op",   5'd7,  64'd5, 64'd3, 64'd0, 1);

        // backpressure: result and in_ready held for 10 cycles
        out_ready = 1'b0;
        op = 5'd4; a = 64'd100; b = 64'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp.lat", N'(lat), N'(65));
        ok = 1'b1;
        repeat (10) begin
            if (res !== 64'd14 || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
            tick();
        end
        check("bp.hold", N'(ok), N'(1));
        check("bp.res", res, 64'd14);
        out_ready = 1'b1;
        tick();
        run_op("after_bp", 5'd4, 64'd100, 64'd7, 64'd14, 65);

        // flush at iteration 20, with a competing request that must be ignored
        out_ready = 1'b1;
        op = 5'd4; a = 64'd1000; b = 64'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (19) tick();
        flush = 1'b1; in_valid = 1'b1; op = 5'd3; a = 64'd9; b = 64'd3;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush.state", N'({out_valid, in_ready}), N'(2'b01));
        ok = 1'b0;
        repeat (80) begin
            tick();
            if (out_valid !== 1'b0) ok = 1'b1;
        end
        check("flush.no_valid", N'(ok), N'(0));
        run_op("after_flush", 5'd4, 64'd1000, 64'd3, 64'd333, 65);

        // flush drops a held result
        out_ready = 1'b0;
        op = 5'd4; a = 64'd5; b = 64'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("hold.valid", N'(out_valid), N'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("hold.flushed", N'({out_valid, in_ready}), N'(2'b01));

        // reset mid-op
        run_op("pre_rst", 5'd4, 64'd1000, 64'd3, 64'd333, 65);
        op = 5'd4; a = 64'd1000; b = 64'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        tick();
        check("mrst.in_ready", N'(in_ready), N'(0));
        check("mrst.out_valid", N'(out_valid), N'(0));
        check("mrst.res", res, '0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst.rel", N'({out_valid, in_ready}), N'(2'b01));
        run_op("after_rst", 5'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
